// File: rtl/fsm_spi_pkg.sv
// Shared definitions for the SPI transmit sequencer: state encoding,
// default word length and shift-register source select codes.
package fsm_spi_pkg;

  localparam int WORD_BITS_DEF = 16;

  localparam logic SEL_HDR  = 1'b0;
  localparam logic SEL_FIFO = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    LOAD_HDR,
    SHIFT_HDR,
    READ,
    LOAD_DATA,
    SHIFT_DATA,
    STOP
  } state_t;

  // Chip select is asserted from the header load until the last data word ends.
  function automatic logic csActive(state_t s);
    return (s == LOAD_HDR) || (s == SHIFT_HDR) || (s == READ) ||
           (s == LOAD_DATA) || (s == SHIFT_DATA);
  endfunction

endpackage

// File: rtl/fsm_spi_if.sv
// Bus between the transmit sequencer and the TX FIFO / shift register.
// master = sequencer side, slave = FIFO and shift-register side.
interface fsm_spi_if;

  logic CSI_CLK;
  logic tx_almost_full;
  logic fifo_tx_empty;
  logic data_sel;
  logic tx_load;
  logic fifo_tx_read_rq;
  logic CS;

  modport master (
    input  CSI_CLK,
    input  tx_almost_full,
    input  fifo_tx_empty,
    output data_sel,
    output tx_load,
    output fifo_tx_read_rq,
    output CS
  );

  modport slave (
    output CSI_CLK,
    output tx_almost_full,
    output fifo_tx_empty,
    input  data_sel,
    input  tx_load,
    input  fifo_tx_read_rq,
    input  CS
  );

endinterface

// File: rtl/fsm_spi_csi_clk_edge_sync.sv
// Brings the slow serial clock into the system clock domain and emits a
// one-cycle pulse for every falling edge.
module csi_clk_edge_sync (
  input  logic clock,
  input  logic reset,
  input  logic CSI_CLK,
  output logic fall
);

  logic sync1_q;
  logic sync2_q;
  logic edge_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync1_q <= CSI_CLK;
      sync2_q <= sync1_q;
      edge_q  <= sync2_q;
    end
  end

  // Built only from flops, so the pulse is glitch-free for the FSM.
  assign fall = edge_q & ~sync2_q;

endmodule

// File: rtl/fsm_spi.sv
// SPI transmit sequencer: frames a header word followed by FIFO words on the
// serial clock, driving chip select, shift-register loads and FIFO pops.
module fsm_spi
  import fsm_spi_pkg::*;
#(
  parameter int WORD_BITS = WORD_BITS_DEF,
  parameter int CNT_W     = 5
) (
  input  logic      clock,
  input  logic      reset,
  fsm_spi_if.master bus
);

  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(WORD_BITS);

  logic fall;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cs_q, cs_d;
  logic             load_q, load_d;
  logic             rd_q, rd_d;
  logic             sel_q, sel_d;

  csi_clk_edge_sync u_edge (
    .clock   (clock),
    .reset   (reset),
    .CSI_CLK (bus.CSI_CLK),
    .fall    (fall)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cs_q    <= 1'b1;
      load_q  <= 1'b0;
      rd_q    <= 1'b0;
      sel_q   <= SEL_HDR;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cs_q    <= cs_d;
      load_q  <= load_d;
      rd_q    <= rd_d;
      sel_q   <= sel_d;
    end
  end

  // FIFO emptiness only matters on the cycle a word finishes shifting.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.tx_almost_full && !bus.fifo_tx_empty) state_d = ALIGN;
      end
      ALIGN: begin
        if (fall) state_d = LOAD_HDR;
      end
      LOAD_HDR: begin
        cnt_d   = '0;
        state_d = SHIFT_HDR;
      end
      SHIFT_HDR: begin
        if (fall) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CNT_DONE) state_d = bus.fifo_tx_empty ? STOP : READ;
        end
      end
      READ: begin
        state_d = LOAD_DATA;
      end
      LOAD_DATA: begin
        cnt_d   = '0;
        state_d = SHIFT_DATA;
      end
      SHIFT_DATA: begin
        if (fall) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CNT_DONE) state_d = bus.fifo_tx_empty ? STOP : READ;
        end
      end
      STOP: begin
        if (fall) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_comb begin
    cs_d   = ~csActive(state_d);
    load_d = (state_d == LOAD_HDR) || (state_d == LOAD_DATA);
    rd_d   = (state_d == READ);
    sel_d  = sel_q;
    if (state_d == LOAD_HDR)  sel_d = SEL_HDR;
    if (state_d == LOAD_DATA) sel_d = SEL_FIFO;
  end

  assign bus.CS              = cs_q;
  assign bus.tx_load         = load_q;
  assign bus.fifo_tx_read_rq = rd_q;
  assign bus.data_sel        = sel_q;

endmodule

// File: tb/tb_fsm_spi.sv
// Self-checking bench for fsm_spi: frame vectors from a table, DUT events
// matched against an expected-event scoreboard, plus reset corner cases.
module tb_fsm_spi;
  import fsm_spi_pkg::*;

  localparam int WB       = 16;
  localparam int CSI_HALF = 5120;
  localparam int CLKS     = 512;

  localparam int EV_CSLOW  = 0;
  localparam int EV_CSHIGH = 1;
  localparam int EV_READ   = 2;
  localparam int EV_LOAD   = 3;
  localparam int EV_NONE   = 7;

  typedef struct {
    int kind;
    int sel;
    int n;
  } evt_t;

  typedef struct {
    int words;
    bit dropAf;
    bit hdrEmpty;
    int expReads;
    int expLoads;
  } vector_t;

  logic clock = 1'b0;
  logic reset = 1'b1;

  fsm_spi_if bus ();

  fsm_spi #(.WORD_BITS(WB), .CNT_W(5)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #10 clock = ~clock;

  initial begin
    bus.CSI_CLK = 1'b1;
    #3;
    forever #CSI_HALF bus.CSI_CLK = ~bus.CSI_CLK;
  end

  int negCount  = 0;
  int readCount = 0;
  int loadCount = 0;
  logic csPrev  = 1'b1;
  evt_t obsQ[$];
  evt_t expQ[$];

  always @(negedge bus.CSI_CLK) negCount++;

  // Turns DUT output activity into events tagged with the current falling-edge count.
  always @(negedge clock) begin
    evt_t ev;
    if (reset) begin
      csPrev = 1'b1;
    end else begin
      if (bus.CS !== csPrev) begin
        ev.kind = bus.CS ? EV_CSHIGH : EV_CSLOW;
        ev.sel  = 0;
        ev.n    = negCount;
        obsQ.push_back(ev);
        csPrev = bus.CS;
      end
      if (bus.fifo_tx_read_rq) begin
        readCount++;
        ev.kind = EV_READ;
        ev.sel  = 0;
        ev.n    = negCount;
        obsQ.push_back(ev);
      end
      if (bus.tx_load) begin
        loadCount++;
        ev.kind = EV_LOAD;
        ev.sel  = int'(bus.data_sel);
        ev.n    = negCount;
        obsQ.push_back(ev);
      end
    end
  end

  int errors = 0;
  int checks = 0;
  int actL = 0;
  bit actArmed = 1'b0;
  bit actDropAf = 1'b0;
  bit actHdrEmpty = 1'b0;
  bit forceEmpty = 1'b1;
  int pushed = 0;
  int lastStopN = 0;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic pushEv(input int kind, input int sel, input int n);
    evt_t e;
    e.kind = kind;
    e.sel  = sel;
    e.n    = n;
    expQ.push_back(e);
  endtask

  task automatic tick();
    evt_t o;
    evt_t e;
    @(negedge clock);
    #1;
    while (obsQ.size() > 0) begin
      o = obsQ.pop_front();
      if (expQ.size() == 0) begin
        checkOutput("unexpectedEvent", o.kind, EV_NONE);
      end else begin
        e = expQ.pop_front();
        checkOutput("eventKind", o.kind, e.kind);
        checkOutput("eventFall", o.n, e.n);
        if (e.kind == EV_LOAD) checkOutput("loadSel", o.sel, e.sel);
      end
    end
    if (actArmed && negCount >= actL + 2) begin
      if (actDropAf)   bus.tx_almost_full = 1'b0;
      if (actHdrEmpty) forceEmpty = 1'b1;
    end
    bus.fifo_tx_empty = forceEmpty || (pushed <= readCount);
  endtask

  task automatic waitDrain(input int budget, input string name);
    int c = 0;
    while (expQ.size() > 0 && c < budget) begin
      tick();
      c++;
    end
    checkOutput(name, expQ.size(), 0);
    expQ.delete();
  endtask

  task automatic waitFall(input int target, input int budget);
    int c = 0;
    while (negCount < target && c < budget) begin
      tick();
      c++;
    end
    checkOutput("fallTimeout", int'(negCount >= target), 1);
  endtask

  task automatic applyStimulus(input vector_t v, input int base, input int off);
    actL        = base + off;
    actDropAf   = v.dropAf;
    actHdrEmpty = v.hdrEmpty;
    actArmed    = 1'b1;
    forceEmpty  = 1'b0;
    pushed      = readCount + v.words;
    bus.tx_almost_full = 1'b1;
    bus.fifo_tx_empty  = 1'b0;
    pushEv(EV_CSLOW, 0, actL);
    pushEv(EV_LOAD, int'(SEL_HDR), actL);
    if (v.hdrEmpty) begin
      lastStopN = actL + WB;
    end else begin
      for (int k = 1; k <= v.words; k++) begin
        pushEv(EV_READ, 0, actL + WB * k);
        pushEv(EV_LOAD, int'(SEL_FIFO), actL + WB * k);
      end
      lastStopN = actL + WB * (v.words + 1);
    end
    pushEv(EV_CSHIGH, 0, lastStopN);
  endtask

  initial begin
    vector_t vecs[2];
    int base;
    int off;
    int reads0;
    int loads0;

    vecs[0] = '{words: 3, dropAf: 1'b1, hdrEmpty: 1'b0, expReads: 3, expLoads: 4};
    vecs[1] = '{words: 1, dropAf: 1'b0, hdrEmpty: 1'b1, expReads: 0, expLoads: 1};

    bus.tx_almost_full = 1'b0;
    bus.fifo_tx_empty  = 1'b1;
    reset = 1'b1;

    for (int i = 0; i < 500; i++) begin
      @(negedge clock);
      bus.tx_almost_full = 1'($urandom_range(0, 1));
      bus.fifo_tx_empty  = 1'($urandom_range(0, 1));
      #1;
      checkOutput("resetOutputs",
                  int'({bus.CS, bus.tx_load, bus.fifo_tx_read_rq, bus.data_sel}), 8);
    end

    @(posedge bus.CSI_CLK);
    @(negedge clock);
    base = negCount;
    off  = 1;
    for (int i = 0; i < 2; i++) begin
      reads0 = readCount;
      loads0 = loadCount;
      applyStimulus(vecs[i], base, off);
      if (i == 0) reset = 1'b0;
      waitDrain(((vecs[i].words + 1) * WB + 4) * CLKS, "frameDrain");
      checkOutput("readPulses", readCount - reads0, vecs[i].expReads);
      checkOutput("loadPulses", loadCount - loads0, vecs[i].expLoads);
      base = lastStopN;
      off  = 2;
    end

    // Reset on the 7th fall of the first data word, then restart.
    reads0    = readCount;
    loads0    = loadCount;
    actArmed  = 1'b0;
    forceEmpty = 1'b0;
    pushed    = readCount + 2;
    bus.tx_almost_full = 1'b1;
    bus.fifo_tx_empty  = 1'b0;
    actL = base + 2;
    pushEv(EV_CSLOW, 0, actL);
    pushEv(EV_LOAD, int'(SEL_HDR), actL);
    pushEv(EV_READ, 0, actL + WB);
    pushEv(EV_LOAD, int'(SEL_FIFO), actL + WB);
    waitDrain((WB + 4) * CLKS, "midFrameDrain");
    waitFall(actL + WB + 7, 10 * CLKS);
    reset = 1'b1;
    #1;
    checkOutput("csOnReset", int'(bus.CS), 1);
    checkOutput("midReads", readCount - reads0, 1);
    checkOutput("midLoads", loadCount - loads0, 2);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      #1;
      checkOutput("resetQuiet", int'({bus.CS, bus.tx_load, bus.fifo_tx_read_rq}), 4);
    end
    obsQ.delete();
    @(negedge clock);
    reset = 1'b0;
    actL = negCount + 1;
    pushEv(EV_CSLOW, 0, actL);
    pushEv(EV_LOAD, int'(SEL_HDR), actL);
    waitDrain(3 * CLKS, "restartDrain");

    // Inconsistent flags must not start a frame.
    reset = 1'b1;
    forceEmpty = 1'b1;
    bus.tx_almost_full = 1'b1;
    bus.fifo_tx_empty  = 1'b1;
    repeat (5) @(negedge clock);
    obsQ.delete();
    loads0 = loadCount;
    reset = 1'b0;
    for (int i = 0; i < 3 * CLKS; i++) tick();
    checkOutput("inconsistentCs", int'(bus.CS), 1);

    // Not almost full: stay idle for 10 serial clock periods.
    bus.tx_almost_full = 1'b0;
    forceEmpty = 1'b0;
    pushed = readCount + 1;
    for (int i = 0; i < 10 * CLKS; i++) tick();
    checkOutput("noStartCs", int'(bus.CS), 1);
    checkOutput("noStartLoads", loadCount - loads0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fsm_spi.md
# fsm_spi

Control sequencer for the SPI transmit path. It watches the transmit FIFO flags and frames transfers on the slow serial clock `CSI_CLK`: it drives chip select, loads the transmit shift register, steers its data mux, and pops words from the FIFO. It sits between the TX FIFO and the SPI shift register and contains no datapath of its own.

## Interface
Parameters:
- `WORD_BITS`, default 16: `CSI_CLK` falling edges per shifted word.
- `CNT_W`, default 5: width of the bit counter; must satisfy `2**CNT_W > WORD_BITS`.

Ports:
- `clock`  in  1  system clock; the only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `CSI_CLK`  in  1  SPI serial clock, asynchronous to `clock` and much slower; sampled as data.
- `tx_almost_full`  in  1  TX FIFO holds enough data to start a frame.
- `fifo_tx_empty`  in  1  TX FIFO empty.
- `data_sel`  out  1  shift-register source: 0 = fixed header word, 1 = FIFO output.
- `tx_load`  out  1  one-cycle pulse that loads the shift register.
- `fifo_tx_read_rq`  out  1  one-cycle FIFO pop request.
- `CS`  out  1  chip select, active low.

## Operation
- `CSI_CLK` passes through a 2-flop synchronizer and an edge register, producing a one-cycle `fall` pulse in the `clock` domain.
- States and transitions:
  - IDLE: `CS`=1. Go to ALIGN when `tx_almost_full`=1 and `fifo_tx_empty`=0.
  - ALIGN: wait for `fall`, then go to LOAD_HDR.
  - LOAD_HDR: one cycle. `data_sel`=0, `tx_load`=1, `CS` goes 0. Clear the counter, then go to SHIFT_HDR.
  - SHIFT_HDR: count `fall` pulses. At `WORD_BITS`, go to STOP if `fifo_tx_empty`=1, otherwise go to READ.
  - READ: one cycle, `fifo_tx_read_rq`=1, then go to LOAD_DATA.
  - LOAD_DATA: one cycle. `data_sel`=1, `tx_load`=1. Clear the counter, then go to SHIFT_DATA.
  - SHIFT_DATA: count `fall`. At `WORD_BITS`, go to READ if `fifo_tx_empty`=0, otherwise go to STOP.
  - STOP: `CS`=1. Wait for one `fall` (guard time), then go to IDLE.
- `CS`=0 in every state from LOAD_HDR through SHIFT_DATA.
- `data_sel` is registered and holds its last value outside the load states.
- `tx_almost_full` only gates frame start. Once a frame has started, it continues until the FIFO is empty.

## Timing
- Reset values: `CS`=1, `tx_load`=0, `fifo_tx_read_rq`=0, `data_sel`=0, state IDLE, counter 0, synchronizer flops 0.
- All outputs are registered and change on the rising edge of `clock`.
- A `CSI_CLK` falling edge produces `fall` 3 `clock` cycles later.
- `fifo_tx_read_rq` precedes `tx_load` by exactly 1 cycle (FIFO read latency 1).
- Gap between words: READ and LOAD_DATA take 2 cycles after the last counted `fall`. The load therefore completes well before the next `CSI_CLK` falling edge.
- `fifo_tx_empty` is sampled only on the cycle the counter reaches `WORD_BITS`.
- A `fall` arriving during LOAD_* or READ is not counted. This cannot occur while `CSI_CLK` half-period exceeds 4 clocks, which is a stated requirement.
- Reset mid-frame: the state machine immediately goes to IDLE and `CS` goes to 1. Any partial word is discarded.
- `tx_almost_full`=1 together with `fifo_tx_empty`=1 (inconsistent flags): remain in IDLE.

## Structure
- Shared package: the state enumeration, the `WORD_BITS` default, and the header-select encodings (`SEL_HDR`=0, `SEL_FIFO`=1).
- One sub-module, `csi_clk_edge_sync`: synchronizer plus falling-edge detector (inputs `clock`, `reset`, `CSI_CLK`; output `fall`).
- The top module holds the state register, the bit counter, and the registered outputs.

## Test plan
- Reset held at 1 for 500 cycles with FIFO flags toggling: `CS`=1, `tx_load`=0, `fifo_tx_read_rq`=0, and `data_sel`=0 throughout.
- Release reset with `tx_almost_full`=1, `fifo_tx_empty`=0, `clock` period 20, `CSI_CLK` period 10240:
  - at the first `fall`, `CS` goes 0, one `tx_load` pulse occurs, and `data_sel`=0;
  - after 16 `fall` pulses, `fifo_tx_read_rq` pulses, then `tx_load` pulses with `data_sel`=1.
- FIFO holding 3 words, `fifo_tx_empty` asserted after the third pop: exactly 3 `fifo_tx_read_rq` pulses and 4 `tx_load` pulses. `CS` rises after 64 `fall` pulses, and the next frame cannot start until one further `fall` has occurred.
- `fifo_tx_empty`=1 at the end of the header: no `fifo_tx_read_rq` pulse, and `CS`=1 after 16 `fall` pulses.
- Reset asserted at the 7th `fall` of a data word: `CS`=1 in the same cycle, no further pulses, and the frame restarts from LOAD_HDR after release.
- `tx_almost_full`=0 with `fifo_tx_empty`=0: `CS` stays 1 and no pulses occur for 10 `CSI_CLK` periods.
